// File: rtl/shiftregister_frame_pkg.sv
// Shared definitions for the serial frame shift engine.
package shiftregister_frame_pkg;

  // Frame engine states.
  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_e;

  // Bit counter width: one spare bit above what width-1 needs.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shiftregister_frame_bitcounter.sv
// Frame bit counter: clear, increment, terminal-count flag at WIDTH-1.
module shiftregister_frame_bitcounter #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = (count_q == CW'(WIDTH - 1));

  // Next count: clear wins; never advance past the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && !tc_o)
      count_d = count_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/shiftregister_frame.sv
// Full-duplex serial shift engine: parallel load, shift out/in on
// peripheral edge strobes, received word reported at frame end.
module shiftregister_frame
  import shiftregister_frame_pkg::*;
#(
  parameter int width    = 8,
  parameter bit lsbFirst = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sampleEdge,
  input  logic             shiftEdge,
  input  logic             csActive,
  input  logic             txValid,
  output logic             txReady,
  input  logic [width-1:0] txData,
  input  logic             serialDataIn,
  output logic             serialDataOut,
  output logic             rxValid,
  output logic [width-1:0] rxData,
  output logic             busy
);

  localparam int CW = cnt_w(width);

  state_e             state_q, state_d;
  logic [width-1:0]   sr_q, sr_d;
  logic [width-1:0]   rxd_q, rxd_d;
  logic               sdo_q, sdo_d;
  logic               rxv_q, rxv_d;

  logic               load, do_sample, do_shift, done;
  logic               cnt_clr, cnt_inc, cnt_tc;
  logic [width-1:0]   shifted;
  logic               out_bit, first_bit;

  shiftregister_frame_bitcounter #(
    .WIDTH (width),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  // Bit-order dependent taps: outgoing bit, first load bit, shifted word.
  always_comb begin
    if (lsbFirst) begin
      shifted   = {serialDataIn, sr_q[width-1:1]};
      out_bit   = sr_q[0];
      first_bit = txData[0];
    end else begin
      shifted   = {sr_q[width-2:0], serialDataIn};
      out_bit   = sr_q[width-1];
      first_bit = txData[width-1];
    end
  end

  // FSM next state and datapath strobes; abort beats sample, sample beats shift.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (txValid) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = SHIFTING;
        end
      end
      SHIFTING: begin
        if (!csActive) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (sampleEdge) begin
          do_sample = 1'b1;
          if (cnt_tc) begin
            done    = 1'b1;
            cnt_clr = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (shiftEdge) begin
          do_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sr_d  = sr_q;
    sdo_d = sdo_q;
    rxd_d = rxd_q;
    rxv_d = done;
    if (load) begin
      sr_d  = txData;
      sdo_d = first_bit;
    end else if (do_sample) begin
      sr_d = shifted;
      if (done) rxd_d = shifted;
    end else if (do_shift) begin
      sdo_d = out_bit;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rxd_q   <= '0;
      sdo_q   <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rxd_q   <= rxd_d;
      sdo_q   <= sdo_d;
      rxv_q   <= rxv_d;
    end
  end

  assign txReady       = (state_q == IDLE);
  assign busy          = (state_q == SHIFTING);
  assign serialDataOut = sdo_q;
  assign rxValid       = rxv_q;
  assign rxData        = rxd_q;

endmodule

// File: tb/tb_shiftregister_frame.sv
// Bench: three engines (w8 MSB-first, w8 LSB-first, w16 MSB-first) with
// a bit-position frame model and directed frames.
module tb_shiftregister_frame;

  localparam int W   [3] = '{8, 8, 16};
  localparam bit LSB [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  se  = '0, sh = '0, cs = '1, tv = '0, sdi = '0;
  logic [15:0] td [3];
  wire  [2:0]  tr, sdo, rv, bsy;
  wire  [7:0]  rd0, rd1;
  wire  [15:0] rd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shiftregister_frame #(.width(8), .lsbFirst(1'b0)) dut0 (
    .clk(clk), .reset(rst), .sampleEdge(se[0]), .shiftEdge(sh[0]), .csActive(cs[0]),
    .txValid(tv[0]), .txReady(tr[0]), .txData(td[0][7:0]), .serialDataIn(sdi[0]),
    .serialDataOut(sdo[0]), .rxValid(rv[0]), .rxData(rd0), .busy(bsy[0]));

  shiftregister_frame #(.width(8), .lsbFirst(1'b1)) dut1 (
    .clk(clk), .reset(rst), .sampleEdge(se[1]), .shiftEdge(sh[1]), .csActive(cs[1]),
    .txValid(tv[1]), .txReady(tr[1]), .txData(td[1][7:0]), .serialDataIn(sdi[1]),
    .serialDataOut(sdo[1]), .rxValid(rv[1]), .rxData(rd1), .busy(bsy[1]));

  shiftregister_frame #(.width(16), .lsbFirst(1'b0)) dut2 (
    .clk(clk), .reset(rst), .sampleEdge(se[2]), .shiftEdge(sh[2]), .csActive(cs[2]),
    .txValid(tv[2]), .txReady(tr[2]), .txData(td[2]), .serialDataIn(sdi[2]),
    .serialDataOut(sdo[2]), .rxValid(rv[2]), .rxData(rd2), .busy(bsy[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_of(input int d);
    case (d)
      0:       return {8'h0, rd0};
      1:       return {8'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  // Bit position of the j-th bit on the wire (both directions share it).
  function automatic int pos(input int d, input int j);
    return LSB[d] ? j : W[d] - 1 - j;
  endfunction

  // ---------------- frame model ----------------
  logic        m_busy [3];
  logic [15:0] m_word [3];
  logic [15:0] m_acc  [3];
  logic [15:0] m_rxd  [3];
  logic        m_sdo  [3];
  logic        m_rxv  [3];
  int          m_k    [3];
  int          m_samp [3];
  int          m_gap  [3];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_word[d] = '0; m_acc[d] = '0; m_rxd[d] = '0;
        m_sdo[d] = 0; m_rxv[d] = 0; m_k[d] = 0; m_samp[d] = 0; m_gap[d] = 0;
      end else begin
        m_rxv[d] = 0;
        if (se[d]) m_samp[d]++;
        if (!m_busy[d]) begin
          if (tv[d]) begin
            m_busy[d] = 1;
            m_word[d] = td[d] & 16'((32'h1 << W[d]) - 1);
            m_k[d]    = 0;
            m_acc[d]  = '0;
            m_sdo[d]  = m_word[d][pos(d, 0)];
          end
        end else if (!cs[d]) begin
          m_busy[d] = 0;
          m_k[d]    = 0;
        end else if (se[d]) begin
          m_acc[d][pos(d, m_k[d])] = sdi[d];
          m_k[d]++;
          if (m_k[d] == W[d]) begin
            m_rxd[d]  = m_acc[d];
            m_rxv[d]  = 1;
            m_busy[d] = 0;
            m_k[d]    = 0;
            m_gap[d]  = m_samp[d];
            m_samp[d] = 0;
          end
        end else if (sh[d]) begin
          m_sdo[d] = m_word[d][pos(d, m_k[d])];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int rv_cnt [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d txReady", d), 32'(tr[d]),  32'(!m_busy[d]));
        chk($sformatf("d%0d busy", d),    32'(bsy[d]), 32'(m_busy[d]));
        chk($sformatf("d%0d sdo", d),     32'(sdo[d]), 32'(m_sdo[d]));
        chk($sformatf("d%0d rxValid", d), 32'(rv[d]),  32'(m_rxv[d]));
        chk($sformatf("d%0d rxData", d),  32'(rd_of(d)), 32'(m_rxd[d]));
        if (rv[d]) rv_cnt[d]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input logic [15:0] w);
    tv[d] = 1'b1; td[d] = w;
    tick();
    tv[d] = 1'b0;
  endtask

  task automatic pair(input int d, input logic b);
    se[d] = 1'b1; sdi[d] = b;
    tick();
    se[d] = 1'b0; sh[d] = 1'b1;
    tick();
    sh[d] = 1'b0;
  endtask

  initial begin
    logic [7:0]  cap;
    logic [7:0]  pat8;
    logic [15:0] pat16;
    for (int d = 0; d < 3; d++) td[d] = '0;

    // Reset state
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst d%0d txReady", d), 32'(tr[d]),  32'h1);
      chk($sformatf("rst d%0d busy", d),    32'(bsy[d]), 32'h0);
      chk($sformatf("rst d%0d sdo", d),     32'(sdo[d]), 32'h0);
      chk($sformatf("rst d%0d rxValid", d), 32'(rv[d]),  32'h0);
      chk($sformatf("rst d%0d rxData", d),  32'(rd_of(d)), 32'h0);
    end
    tick();
    rst = 1'b0;
    tick();

    // MSB-first: 0xA5 out, 0x3C in
    load(0, 16'h00A5);
    chk("t1 busy after load", 32'(bsy[0]), 32'h1);
    pat8 = 8'h3C; cap = '0;
    for (int k = 0; k < 8; k++) begin
      cap = {cap[6:0], sdo[0]};
      pair(0, pat8[7-k]);
    end
    chk("t1 sdo sequence", 32'(cap), 32'hA5);
    chk("t1 rxData", 32'(rd0), 32'h3C);
    chk("t1 rxValid count", 32'(rv_cnt[0]), 32'd1);

    // LSB-first: 0x01 out, sdi 1,1,0.. -> 0x03
    load(1, 16'h0001);
    pat8 = 8'b1100_0000; cap = '0;
    for (int k = 0; k < 8; k++) begin
      cap = {cap[6:0], sdo[1]};
      pair(1, pat8[7-k]);
    end
    chk("t2 sdo sequence", 32'(cap), 32'h80);
    chk("t2 rxData", 32'(rd1), 32'h03);

    // Abort after 3 samples, then a full frame of ones
    load(0, 16'h005A);
    for (int k = 0; k < 3; k++) pair(0, 1'b1);
    cs[0] = 1'b0;
    tick();
    chk("t3 txReady after abort", 32'(tr[0]), 32'h1);
    chk("t3 rxValid after abort", 32'(rv[0]), 32'h0);
    chk("t3 rxData held", 32'(rd0), 32'h3C);
    cs[0] = 1'b1;
    tick();
    chk("t3 no pulse on abort", 32'(rv_cnt[0]), 32'd1);
    load(0, 16'h0000);
    for (int k = 0; k < 8; k++) pair(0, 1'b1);
    chk("t3 rxData ones", 32'(rd0), 32'hFF);
    chk("t3 rxValid count", 32'(rv_cnt[0]), 32'd2);

    // Load ignored while shifting; coincident edges
    load(0, 16'h0096);
    pair(0, 1'b0);
    pair(0, 1'b0);
    tv[0] = 1'b1; td[0] = 16'h0055;
    tick();
    tv[0] = 1'b0;
    chk("t4 busy despite txValid", 32'(bsy[0]), 32'h1);
    chk("t4 sdo before both", 32'(sdo[0]), 32'h0);
    se[0] = 1'b1; sh[0] = 1'b1; sdi[0] = 1'b1;
    tick();
    se[0] = 1'b0; sh[0] = 1'b0;
    chk("t4 sdo after both", 32'(sdo[0]), 32'h0);
    pair(0, 1'b0);
    chk("t4 sdo bit4", 32'(sdo[0]), 32'h0);
    for (int k = 0; k < 4; k++) pair(0, 1'b0);
    chk("t4 rxData", 32'(rd0), 32'h20);
    chk("t4 rxValid count", 32'(rv_cnt[0]), 32'd3);

    // Reset mid-frame after 5 samples
    load(1, 16'h00F0);
    for (int k = 0; k < 5; k++) pair(1, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t5 sdo in reset", 32'(sdo[1]), 32'h0);
    chk("t5 busy in reset", 32'(bsy[1]), 32'h0);
    chk("t5 txReady in reset", 32'(tr[1]), 32'h1);
    chk("t5 rxValid in reset", 32'(rv[1]), 32'h0);
    chk("t5 rxData in reset", 32'(rd1), 32'h0);
    #1 rst = 1'b0;
    tick();
    load(1, 16'h0001);
    pat8 = 8'b1100_0000;
    for (int k = 0; k < 8; k++) pair(1, pat8[7-k]);
    chk("t5 rxData after reset", 32'(rd1), 32'h03);
    chk("t5 rxValid count", 32'(rv_cnt[1]), 32'd2);

    // Width 16, back-to-back frames
    load(2, 16'h8001);
    pat16 = 16'h1234;
    for (int k = 0; k < 15; k++) pair(2, pat16[15-k]);
    se[2] = 1'b1; sdi[2] = pat16[0];
    tick();
    se[2] = 1'b0;
    chk("t6 rxValid first", 32'(rv[2]), 32'h1);
    chk("t6 rxData first", 32'(rd2), 32'h1234);
    chk("t6 txReady in rxValid cycle", 32'(tr[2]), 32'h1);
    load(2, 16'hC3A5);
    chk("t6 busy second", 32'(bsy[2]), 32'h1);
    chk("t6 sdo second first bit", 32'(sdo[2]), 32'h1);
    pat16 = 16'hBEEF;
    for (int k = 0; k < 16; k++) pair(2, pat16[15-k]);
    chk("t6 rxData second", 32'(rd2), 32'hBEEF);
    chk("t6 rxValid count", 32'(rv_cnt[2]), 32'd2);
    chk("t6 sample gap", 32'(m_gap[2]), 32'd16);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
